// File: rtl/axil_sub_pkg.sv
// rtl/axil_sub_pkg.sv - shared widths, response codes and byte-merge helper for the AXI-Lite register slice
package axil_sub_pkg;

  localparam int REG_WIDTH = 32;
  localparam int STRB_WIDTH = REG_WIDTH / 8;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic logic [REG_WIDTH-1:0] byte_merge(
    input logic [REG_WIDTH-1:0]  old_word,
    input logic [REG_WIDTH-1:0]  new_word,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [REG_WIDTH-1:0] merged;
    merged = old_word;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_sub_regfile.sv
// rtl/axil_sub_regfile.sv - register storage with byte-strobe writes and a zero-filling read mux
import axil_sub_pkg::*;

module axil_sub_regfile #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [IDX_W-1:0]              widx,
  input  logic [REG_WIDTH-1:0]          wdata,
  input  logic [STRB_WIDTH-1:0]         wstrb,
  output logic                          w_hit,
  input  logic [IDX_W-1:0]              ridx,
  output logic [REG_WIDTH-1:0]          rdata,
  output logic                          r_hit,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_out
);

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs;

  // Indices past NUM_REGS match no entry, so unmapped writes fall through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (we) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (int'(widx) == i) regs[i] <= byte_merge(regs[i], wdata, wstrb);
      end
    end
  end

  always_comb begin
    rdata = '0;
    r_hit = 1'b0;
    w_hit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(ridx) == i) begin
        rdata = regs[i];
        r_hit = 1'b1;
      end
      if (int'(widx) == i) w_hit = 1'b1;
    end
  end

  assign reg_out = regs;

endmodule

// File: rtl/axil_sub_regs.sv
// rtl/axil_sub_regs.sv - AXI4-Lite slave handshake front end over axil_sub_regfile
// Define AXIL_SUB_SLVERR_EN to answer unmapped accesses with SLVERR instead of OKAY.
import axil_sub_pkg::*;

module axil_sub_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_REGS*REG_WIDTH-1:0]   reg_out
);

  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

`ifdef AXIL_SUB_SLVERR_EN
  localparam resp_t MISS_RESP = RESP_SLVERR;
`else
  localparam resp_t MISS_RESP = RESP_OKAY;
`endif

  logic                            aw_held;
  logic                            w_held;
  logic [IDX_W-1:0]                aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]   w_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                            aw_hs;
  logic                            w_hs;
  logic                            ar_hs;
  logic                            commit;
  logic                            w_hit;
  logic                            r_hit;
  logic [REG_WIDTH-1:0]            rd_word;
  logic                            unused_ok;

  // Readies are gated by reset so they read 0 while held in reset yet are live on the first edge after release.
  assign s00_axi_awready = s00_axi_aresetn & ~aw_held & ~s00_axi_bvalid;
  assign s00_axi_wready  = s00_axi_aresetn & ~w_held & ~s00_axi_bvalid;
  assign s00_axi_arready = s00_axi_aresetn & ~s00_axi_rvalid;

  assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
  assign w_hs   = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
  assign commit = aw_held & w_held;

  assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                       s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held <= 1'b1;
          aw_idx  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        end
        if (w_hs) begin
          w_held <= 1'b1;
          w_data <= s00_axi_wdata;
          w_strb <= s00_axi_wstrb;
        end
      end

      if (commit) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= w_hit ? RESP_OKAY : MISS_RESP;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Read data is sampled before the regfile edge update, so a colliding commit returns the old word.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_word;
      s00_axi_rresp  <= r_hit ? RESP_OKAY : MISS_RESP;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  axil_sub_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .we      (commit),
    .widx    (aw_idx),
    .wdata   (w_data),
    .wstrb   (w_strb),
    .w_hit   (w_hit),
    .ridx    (s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]),
    .rdata   (rd_word),
    .r_hit   (r_hit),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_axil_sub_regs.sv
// tb/tb_axil_sub_regs.sv - scoreboard bench for axil_sub_regs with a word-array reference model
module tb_axil_sub_regs;

  localparam int NREG = 4;

`ifdef AXIL_SUB_SLVERR_EN
  localparam logic [1:0] MISS = 2'b10;
`else
  localparam logic [1:0] MISS = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] awaddr = '0;
  logic [2:0] awprot = '0;
  logic awvalid = 1'b0;
  logic awready;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic wvalid = 1'b0;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready = 1'b0;
  logic [4:0] araddr = '0;
  logic [2:0] arprot = '0;
  logic arvalid = 1'b0;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready = 1'b0;
  logic [NREG*32-1:0] reg_out;

  always #5 clk = ~clk;

  axil_sub_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_out         (reg_out)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  logic [31:0] model[NREG];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          hold_b_low = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out, required a handshake within bound", name);
  endtask

  function automatic bit mapped(input logic [4:0] a);
    return (a >> 2) < NREG;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [4:0] a);
    return mapped(a) ? 2'b00 : MISS;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [4:0] a);
    return mapped(a) ? model[a >> 2] : 32'h0;
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NREG; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    if (mapped(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a >> 2][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic drive_aw(input logic [4:0] a, input int dly);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awprot = 3'($urandom); awvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = awready; end
    if (!ok) timeout("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = wready; end
    if (!ok) timeout("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic drive_ar(input logic [4:0] a, input int dly);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); ok = arready; end
    if (!ok) timeout("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); #1; ok = (b_q.size() == 0); end
    if (!ok) timeout("b_response");
  endtask

  task automatic wait_r();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin @(negedge clk); #1; ok = (r_q.size() == 0); end
    if (!ok) timeout("r_response");
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int daw, input int dw);
    b_q.push_back(exp_resp(a));
    model_write(a, d, s);
    fork
      drive_aw(a, daw);
      drive_w(d, s, dw);
    join
    wait_b();
    check("reg_out", reg_out, model_flat());
  endtask

  task automatic do_read(input logic [4:0] a);
    r_q.push_back('{d: exp_rdata(a), r: exp_resp(a)});
    drive_ar(a, 0);
    wait_r();
  endtask

  task automatic check_reset_state();
    check("rst_ctrl", 128'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 128'(0));
    check("rst_rdata", 128'(rdata), 128'(0));
    check("rst_reg_out", reg_out, 128'(0));
  endtask

  // Ready generators: random backpressure, with bready forceable low for the stall scenario.
  initial forever begin
    @(posedge clk); #1;
    bready = hold_b_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    rready = ($urandom_range(0, 3) != 0);
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && bvalid) begin
      if (b_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL b_spurious: bvalid=1 required=0");
      end else begin
        check("bresp", 128'(bresp), 128'(b_q[0]));
        if (bready) b_q.delete(0);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && rvalid) begin
      if (r_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL r_spurious: rvalid=1 required=0");
      end else begin
        check("rdata", 128'(rdata), 128'(r_q[0].d));
        check("rresp", 128'(rresp), 128'(r_q[0].r));
        if (rready) r_q.delete(0);
      end
    end
  end

  initial begin
    #2_000_000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    bit ok;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Sequential write then read-back.
    for (int i = 0; i < 4; i++) do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(5'(4 * i));

    // Byte strobes.
    do_write(5'h00, 32'hAABBCCDD, 4'hF, 0, 1);
    do_write(5'h00, 32'h11223344, 4'h5, 1, 0);
    check("strobe_merge", 128'(reg_out[31:0]), 128'(32'hAA22CC44));
    do_read(5'h00);

    // W three cycles ahead of AW, with bready held low for five cycles.
    hold_b_low = 1'b1;
    bready = 1'b0;
    b_q.push_back(2'b00);
    model_write(5'h08, 32'hCAFE0001, 4'hF);
    fork
      drive_aw(5'h08, 3);
      drive_w(32'hCAFE0001, 4'hF, 0);
    join
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = bvalid; end
    if (!ok) timeout("stall_bvalid");
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_hold", 128'({bvalid, awready, wready}), 128'(3'b100));
    end
    hold_b_low = 1'b0;
    wait_b();
    check("stall_reg_out", reg_out, model_flat());

    // Read handshake on the same edge as a commit to the same register.
    do_write(5'h04, 32'h5, 4'hF, 0, 0);
    r_q.push_back('{d: 32'h5, r: 2'b00});
    b_q.push_back(2'b00);
    model_write(5'h04, 32'h9, 4'hF);
    fork
      drive_aw(5'h04, 0);
      drive_w(32'h9, 4'hF, 0);
      drive_ar(5'h04, 1);
    join
    wait_b();
    wait_r();
    r_q.push_back('{d: 32'h9, r: 2'b00});
    drive_ar(5'h04, 0);
    wait_r();

    // Unmapped address.
    do_write(5'h10, 32'hFFFFFFFF, 4'hF, 0, 0);
    do_read(5'h10);
    do_write(5'h0C, 32'h12345678, 4'h0, 0, 0);

    // Randomized mix of writes and reads across mapped and unmapped addresses.
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      else
        do_read(5'($urandom_range(0, 31)));
    end

    // Reset between an accepted AW and its W.
    drive_aw(5'h0C, 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    #1;
    check("post_reset_ready", 128'({awready, wready, arready}), 128'(3'b111));
    repeat (6) @(negedge clk);
    check("post_reset_reg_out", reg_out, 128'(0));
    do_write(5'h0C, 32'h0BADF00D, 4'hF, 0, 0);
    do_read(5'h0C);

    repeat (10) @(negedge clk);
    check("queues_drained", 128'(b_q.size() + r_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_sub_regs.md
AXIL_SUB_REGS -- requirements
Module: axil_sub_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of 32-bit registers.
REQ-004 SHALL have ports, in this order:
- s00_axi_aclk in 1: the single clock.
- s00_axi_aresetn in 1: reset, asynchronous, active-low.
- s00_axi_awaddr in C_S_AXI_ADDR_WIDTH: write address.
- s00_axi_awprot in 3: write protection; ignored.
- s00_axi_awvalid in 1, s00_axi_awready out 1: AW handshake.
- s00_axi_wdata in 32: write data.
- s00_axi_wstrb in 4: byte enables.
- s00_axi_wvalid in 1, s00_axi_wready out 1: W handshake.
- s00_axi_bresp out 2, s00_axi_bvalid out 1, s00_axi_bready in 1: write response.
- s00_axi_araddr in C_S_AXI_ADDR_WIDTH: read address.
- s00_axi_arprot in 3: read protection; ignored.
- s00_axi_arvalid in 1, s00_axi_arready out 1: AR handshake.
- s00_axi_rdata out 32, s00_axi_rresp out 2, s00_axi_rvalid out 1, s00_axi_rready in 1: read data.
- reg_out out NUM_REGS*32: live register contents to fabric; reg i occupies bits [32i+31:32i].

Function
REQ-005 SHALL decode register index as awaddr/araddr[C_S_AXI_ADDR_WIDTH-1:2]; address bits [1:0] are ignored; index >= NUM_REGS is unmapped.
REQ-006 SHALL capture AW and W independently into holding registers, in either order or in the same cycle.
REQ-007 SHALL assert awready only while no AW is held and bvalid is low; SHALL assert wready only while no W is held and bvalid is low.
REQ-008 SHALL commit the write on the first rising edge on which both AW and W are held.
- Commit updates each byte of the mapped register whose wstrb bit is 1.
- On the same edge the commit SHALL assert bvalid and clear both holds.
- AW and W accepted on the same edge therefore give bvalid two cycles after the handshake.
REQ-009 SHALL hold bvalid and bresp stable until the edge on which bready is high, then deassert bvalid.
REQ-010 SHALL assert arready only while rvalid is low.
REQ-011 SHALL register rdata and rresp on the AR handshake edge and assert rvalid in the next cycle (latency 1). SHALL hold rdata, rresp and rvalid stable until the rready handshake.
REQ-012 If a read handshake and a write commit to the same register occur on the same edge, the read SHALL return the pre-write value.
REQ-013 Unmapped writes SHALL change no register. Unmapped reads SHALL return rdata 0.
REQ-014 wstrb=0 SHALL complete the write with bresp OKAY and change no data.
REQ-015 The read and write paths SHALL operate concurrently without mutual stalls.

Reset
REQ-016 While s00_axi_aresetn is low, all outputs SHALL be 0: awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata, and every register/reg_out.
REQ-017 Reset asserted mid-transaction SHALL discard held AW/W and any pending B/R responses. After release, the first handshake SHALL be accepted on the first clock edge.

Configuration
REQ-018 With macro AXIL_SUB_SLVERR_EN defined, unmapped accesses SHALL respond bresp/rresp = 2'b10 (SLVERR). Without it, all responses SHALL be 2'b00 (OKAY). REQ-013 applies in both cases.

Structure
REQ-019 Package axil_sub_pkg SHALL hold:
- response codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
- REG_WIDTH=32;
- typedef for the 2-bit response.
REQ-020 Register storage, byte-strobe update and read mux SHALL be sub-module axil_sub_regfile. axil_sub_regs SHALL contain the handshake logic only.

Verification
REQ-021 Sequential write/read: write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC with wstrb=0xF, then read back -> rdata 0x1..0x4, all responses OKAY, reg_out matches.
REQ-022 Byte strobe: reg0=0xAABBCCDD, then write 0x11223344 with wstrb=0x5 -> read 0xAA22CC44.
REQ-023 W valid 3 cycles before AW, and bready held low 5 cycles -> single commit, bvalid stays high with stable bresp until bready, awready/wready stay low meanwhile.
REQ-024 Same-edge read/write: reg1=0x5, AR and commit of 0x9 to 0x4 on the same edge -> rdata 0x5; next read -> 0x9.
REQ-025 Unmapped 0x10: write 0xFFFFFFFF and read -> rdata 0, registers unchanged, resp SLVERR with AXIL_SUB_SLVERR_EN and OKAY without.
REQ-026 Reset mid-write: assert aresetn low after AW accepted, before W -> bvalid never asserts, all registers 0 after release.
